// File: rtl/median_loader_pkg.sv
// median_loader_pkg
// Shared definitions for the median window write sequencer:
//   state_t                      loader FSM states (IDLE/WRITE/WAIT/HOLD)
//   SEL_MEDIAN/SEL_RESID/SEL_PASS read-back select codes of the window block
//   DATA_W_DEF/DEPTH_DEF/MED_LAT_DEF default parameter values
package median_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_MEDIAN = 2'b00;
    localparam logic [1:0] SEL_RESID  = 2'b01;
    localparam logic [1:0] SEL_PASS   = 2'b10;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int MED_LAT_DEF = 2;

endpackage

// File: rtl/median_loader.sv
// median_loader
// Host-side write sequencer for the median sample window. Accepts samples on
// a valid/ready handshake, writes each into the next window slot, and once
// the window is full waits out the median latency after every write, then
// captures the median read-back and offers it downstream.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous, active-low reset
//   flush    synchronous restart of the window fill (one-cycle pulse)
//   s_data / s_valid / s_ready   sample input handshake
//   wr_data / wr_addr / wr_en    window write port
//   out_sel  read-back select to the window block (always SEL_MEDIAN)
//   rd_data  median read-back from the window block
//   m_data / m_resid / m_valid / m_ready   result output handshake
//
// Optional feature: define MEDIAN_LOADER_RESID_EN to register
// m_resid = sample - median (mod 2^DATA_W) alongside m_data; otherwise
// m_resid is tied to zero.
module median_loader
    import median_loader_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MED_LAT = MED_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic                     wr_en,
    output logic [1:0]               out_sel,
    input  logic [DATA_W-1:0]        rd_data,
    output logic [DATA_W-1:0]        m_data,
    output logic [DATA_W-1:0]        m_resid,
    output logic                     m_valid,
    input  logic                     m_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(MED_LAT + 1);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   ptr_q;
    logic [FW-1:0]   fill_q;
    logic [FW-1:0]   fill_inc;
    logic [CW-1:0]   cnt_q;

    logic            s_ready_d;
    logic            wr_en_d;
    logic            m_valid_d;
    logic            load_sample;
    logic            capture;

    // Fill count after the current write; stays at DEPTH once the window
    // has been filled, so every later write yields a result.
    always_comb begin
        fill_inc = fill_q;
        if (fill_q != FW'(DEPTH)) begin
            fill_inc = fill_q + 1'b1;
        end
    end

    // Next-state logic. flush overrides everything, including a handshake
    // in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (s_valid && s_ready) state_d = WRITE;
                WRITE:   state_d = (fill_inc < FW'(DEPTH)) ? IDLE : WAIT;
                WAIT:    if (cnt_q <= CW'(1)) state_d = HOLD;
                HOLD:    if (m_valid && m_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Registered outputs are derived from the state being entered, so each
    // output is valid in the same cycle as its state.
    always_comb begin
        s_ready_d   = (state_d == IDLE);
        wr_en_d     = (state_d == WRITE);
        m_valid_d   = (state_d == HOLD);
        load_sample = (state_q == IDLE) && (state_d == WRITE);
        capture     = (state_q == WAIT) && (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            s_ready <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            out_sel <= SEL_MEDIAN;
            m_data  <= '0;
            m_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            s_ready <= s_ready_d;
            wr_en   <= wr_en_d;
            m_valid <= m_valid_d;
            out_sel <= SEL_MEDIAN;

            // wr_data doubles as the latched sample for the residual.
            if (load_sample) begin
                wr_data <= s_data;
                wr_addr <= ptr_q;
            end

            if (flush) begin
                ptr_q  <= '0;
                fill_q <= '0;
            end else if (state_q == WRITE) begin
                ptr_q  <= ptr_q + 1'b1;
                fill_q <= fill_inc;
                if (state_d == WAIT) begin
                    cnt_q <= CW'(MED_LAT);
                end
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (capture) begin
                m_data <= rd_data;
            end
        end
    end

`ifdef MEDIAN_LOADER_RESID_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_resid <= '0;
        end else if (capture) begin
            m_resid <= wr_data - rd_data;
        end
    end
`else
    assign m_resid = '0;
`endif

endmodule

// File: doc/median_loader.md
# median_loader

Host-side write sequencer for the median sample window. It accepts a byte stream on a valid/ready handshake and writes each sample into the next slot of the 8-entry window through the window's write port (data, slot address, write enable). Once the window is full, it waits out the median pipeline latency after every write, captures the median read-back and presents it downstream on a second valid/ready handshake. It sits between the sample source and the median window/processor block, and is the only writer of that window.

## Interface
- DATA_W, 8: sample and median width.
- DEPTH, 8: window slots; power of two; address width is log2(DEPTH).
- MED_LAT, 2: cycles from the window-write edge until the median read-back is valid; minimum 1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous restart of window fill; one-cycle pulse.
- s_data  in  DATA_W  input sample.
- s_valid  in  1  sample valid.
- s_ready  out  1  loader can accept a sample.
- wr_data  out  DATA_W  sample to the window.
- wr_addr  out  log2(DEPTH)  window slot.
- wr_en  out  1  window write strobe, one cycle per sample.
- out_sel  out  2  read-back select to the window block; constant 2'b00 (median).
- rd_data  in  DATA_W  median read-back from the window block.
- m_data  out  DATA_W  captured median.
- m_resid  out  DATA_W  sample minus median; see Configuration.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.

## Operation
- All outputs are registered. Reset values: s_ready 0, wr_en 0, wr_addr 0, wr_data 0, out_sel 2'b00, m_data 0, m_resid 0, m_valid 0. Internal state: state IDLE, ptr 0, fill 0.
- FSM states: IDLE, WRITE, WAIT, HOLD.
- IDLE: s_ready=1. On s_valid&&s_ready: latch s_data, go to WRITE, drop s_ready.
- WRITE: wr_en=1, wr_addr=ptr, wr_data=latched sample for exactly one cycle. Then ptr increments (DEPTH-1 wraps to 0) and fill increments, saturating at DEPTH.
  - If the saturated fill is below DEPTH, return to IDLE.
  - Otherwise load the wait counter with MED_LAT and go to WAIT.
- WAIT: decrement the counter. When it reaches 0, capture rd_data into m_data, set m_valid and go to HOLD.
- HOLD: m_valid=1, and m_data/m_resid are held stable until m_valid&&m_ready. Then clear m_valid, raise s_ready and go to IDLE. s_ready=0 throughout HOLD, so no write can occur while a result is pending.
- flush in any state:
  - ptr and fill return to 0; state goes to IDLE; m_valid and wr_en clear next cycle.
  - Any pending result is discarded. A handshake in the same cycle as flush is ignored.
  - Window contents are not cleared. Stale slots are overwritten before the next result, because DEPTH new writes are required.
- Asynchronous reset mid-operation returns everything to reset values immediately. A write in flight is dropped.

## Timing
- Sample handshake at cycle 0 → wr_en high in cycle 1 → window updated at the end of cycle 1.
- Window not full: s_ready high again in cycle 2, giving a maximum throughput of 1 sample per 2 cycles.
- Window full: m_valid rises in cycle 2+MED_LAT (cycle 4 at the default). With m_ready held high, s_ready rises in cycle 3+MED_LAT.
- s_ready rises in the first cycle after rst deasserts.

## Configuration
- MEDIAN_LOADER_RESID_EN defined:
  - At capture, m_resid = latched sample − rd_data, computed modulo 2^DATA_W (wrap-around, no saturation).
  - m_resid is registered together with m_data.
- Not defined: m_resid is tied to 0 and there is no subtractor. All other behaviour is identical.

## Structure
- Shared package median_loader_pkg holds:
  - the state enum (IDLE/WRITE/WAIT/HOLD);
  - out_sel codes: SEL_MEDIAN=2'b00, SEL_RESID=2'b01, SEL_PASS=2'b10;
  - default DATA_W/DEPTH constants.
- No sub-module; the FSM, pointer, fill counter and wait counter live in one module.

## Test plan
All scenarios use default parameters. The bench's window model returns rd_data MED_LAT cycles after a write.
- Reset: rst low for 3 cycles mid-stream → all outputs 0; s_ready=1 in the first cycle after release.
- Fill: samples 10,20,…,80 back-to-back → wr_addr 0..7 with matching wr_data; no m_valid for samples 1–7. After sample 8 the model returns 45 → m_data=45, with m_valid exactly 4 cycles after the 8th handshake.
- Backpressure: m_ready low for 5 cycles in HOLD → m_data stays 45, s_ready stays 0, no wr_en. Raising m_ready gives a single-cycle m_valid&&m_ready, followed by s_ready=1 the next cycle.
- Wrap: 9th sample 90 → wr_addr=0, wr_data=90, and a new result is produced 4 cycles after its handshake.
- Flush: flush after 5 samples (with s_valid high in the same cycle) → that sample is not written; the next 8 samples use wr_addr 0..7 and produce exactly one m_valid, after the 8th.
- Macro on: sample 0x10 with model median 0x20 → m_resid=0xF0. Macro off: m_resid=0 throughout.
